mdu_iter: RTL and testbench

- Iterative RV32M/RV64M multiply-divide unit. It is the sequential, parametrised companion to the single-cycle integer ALU.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, selected by funct3.
- Uses a valid/ready handshake on both input and output. Sits beside the ALU in the execute stage; the core stalls while busy.

---
 rtl/mdu_iter_pkg.sv | 30 +++
 rtl/mdu_sign_fix.sv | 38 +++
 rtl/mdu_iter.sv | 175 +++++++++++++++++
 tb/tb_mdu_iter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 codes,
// FSM state encoding and XLEN-dependent constants.
package mdu_iter_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Most negative XLEN-bit value, returned in a 64-bit container.
  function automatic logic [63:0] mdu_min_val(input int xlen);
    return 64'(1) << (xlen - 1);
  endfunction

  // All-ones XLEN-bit value (the shift wraps to zero for xlen=64).
  function automatic logic [63:0] mdu_ones_val(input int xlen);
    return (64'(1) << xlen) - 64'(1);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign correction and result selection for the MDU; operates on
// unsigned magnitudes plus the operand sign flags.
module mdu_sign_fix
  import mdu_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        i_funct3,
  input  logic              i_neg1,
  input  logic              i_neg2,
  input  logic [2*XLEN-1:0] i_prod,
  input  logic [XLEN-1:0]   i_quo,
  input  logic [XLEN-1:0]   i_rem,
  output logic [XLEN-1:0]   o_result
);

  logic              w_neg_diff;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;

  assign w_neg_diff = i_neg1 ^ i_neg2;
  assign w_prod_fix = w_neg_diff ? -i_prod : i_prod;
  assign w_quo_fix  = w_neg_diff ? -i_quo  : i_quo;
  // Remainder follows the dividend's sign.
  assign w_rem_fix  = i_neg1     ? -i_rem  : i_rem;

  always_comb begin
    o_result = w_rem_fix;
    case (i_funct3)
      MDU_MUL:                         o_result = w_prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: o_result = w_prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               o_result = w_quo_fix;
      default:                         o_result = w_rem_fix;
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply-divide unit (shift-add multiply, restoring divide).
// Optional MDU_FAST_MUL_EN: single-cycle multiplier for MUL* ops.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [63:0]     MIN64   = mdu_min_val(XLEN);
  localparam logic [63:0]     ONES64  = mdu_ones_val(XLEN);
  localparam logic [XLEN-1:0] MIN_V   = MIN64[XLEN-1:0];
  localparam logic [XLEN-1:0] ONES_V  = ONES64[XLEN-1:0];

  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_op;
  logic              r_s1;
  logic              r_s2;
  logic [XLEN-1:0]   r_a;
  logic [2*XLEN:0]   r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;

  logic              w_signed1;
  logic              w_signed2;
  logic              w_neg1;
  logic              w_neg2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_fast_mul;
  logic              w_accept;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN:0]   w_mul_step;
  logic [XLEN:0]     w_div_sh;
  logic [XLEN:0]     w_div_diff;
  logic [2*XLEN:0]   w_div_step;
  logic [XLEN-1:0]   w_fix_res;

  assign w_signed1  = (funct3 == MDU_MULH) || (funct3 == MDU_MULHSU) ||
                      (funct3 == MDU_DIV)  || (funct3 == MDU_REM);
  assign w_signed2  = (funct3 == MDU_MULH) || (funct3 == MDU_DIV) || (funct3 == MDU_REM);
  assign w_neg1     = w_signed1 & in1[XLEN-1];
  assign w_neg2     = w_signed2 & in2[XLEN-1];
  assign w_mag1     = w_neg1 ? -in1 : in1;
  assign w_mag2     = w_neg2 ? -in2 : in2;
  assign w_div_zero = funct3[2] && (in2 == '0);
  assign w_div_ovf  = ((funct3 == MDU_DIV) || (funct3 == MDU_REM)) &&
                      (in1 == MIN_V) && (in2 == ONES_V);
  assign w_accept   = (r_state == ST_IDLE) && in_valid && !flush;

`ifdef MDU_FAST_MUL_EN
  logic [XLEN:0]           w_ext1;
  logic [XLEN:0]           w_ext2;
  logic signed [2*XLEN+1:0] w_fast_full;
  logic [XLEN-1:0]         w_fast_res;

  assign w_fast_mul  = !funct3[2];
  assign w_ext1      = {w_signed1 & in1[XLEN-1], in1};
  assign w_ext2      = {w_signed2 & in2[XLEN-1], in2};
  assign w_fast_full = $signed(w_ext1) * $signed(w_ext2);

  mdu_sign_fix #(.XLEN(XLEN)) u_fast_fix (
    .i_funct3 (funct3),
    .i_neg1   (1'b0),
    .i_neg2   (1'b0),
    .i_prod   (w_fast_full[2*XLEN-1:0]),
    .i_quo    (in1),
    .i_rem    (in2),
    .o_result (w_fast_res)
  );
`else
  assign w_fast_mul = 1'b0;
`endif

  // Multiply: add multiplicand into the high half when the LSB is set, then shift right.
  assign w_mul_sum  = r_acc[0] ? (r_acc[2*XLEN:XLEN] + {1'b0, r_a}) : r_acc[2*XLEN:XLEN];
  assign w_mul_step = {1'b0, w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
  assign w_div_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_a};
  assign w_div_step = w_div_diff[XLEN] ? {w_div_sh,   r_acc[XLEN-2:0], 1'b0}
                                       : {w_div_diff, r_acc[XLEN-2:0], 1'b1};

  mdu_sign_fix #(.XLEN(XLEN)) u_fix (
    .i_funct3 (r_op),
    .i_neg1   (r_s1),
    .i_neg2   (r_s2),
    .i_prod   (r_acc[2*XLEN-1:0]),
    .i_quo    (r_acc[XLEN-1:0]),
    .i_rem    (r_acc[2*XLEN-1:XLEN]),
    .o_result (w_fix_res)
  );

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid)
                   w_state_next = (w_div_zero || w_div_ovf || w_fast_mul) ? ST_DONE : ST_CALC;
        ST_CALC: if (r_cnt == CNT_W'(1)) w_state_next = ST_FIX;
        ST_FIX:  w_state_next = ST_DONE;
        default: if (out_ready) w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    busy      = (r_state != ST_IDLE);
    out_valid = (r_state == ST_DONE);
    result    = r_result;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_op     <= '0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_a      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op  <= funct3;
      r_s1  <= w_neg1;
      r_s2  <= w_neg2;
      r_cnt <= CNT_W'(XLEN);
      if (funct3[2]) begin
        r_a   <= w_mag2;
        r_acc <= {{(XLEN+1){1'b0}}, w_mag1};
      end else begin
        r_a   <= w_mag1;
        r_acc <= {{(XLEN+1){1'b0}}, w_mag2};
      end
      if (w_div_zero)
        r_result <= funct3[1] ? in1 : ONES_V;
      else if (w_div_ovf)
        r_result <= funct3[1] ? '0 : MIN_V;
`ifdef MDU_FAST_MUL_EN
      else if (w_fast_mul)
        r_result <= w_fast_res;
`endif
    end else if (!flush && (r_state == ST_CALC)) begin
      r_acc <= r_op[2] ? w_div_step : w_mul_step;
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (!flush && (r_state == ST_FIX)) begin
      r_result <= w_fix_res;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter (XLEN=32): directed vectors, random ops against
// a behavioural model, DONE hold, flush and mid-operation reset.
module tb_mdu_iter;

  localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif
  localparam int DIV_LAT = XLEN + 2;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] in1 = '0;
  logic [XLEN-1:0] in2 = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            busy;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] ub_s;
    logic [63:0]        ua;
    logic [63:0]        ub;
    logic [63:0]        p;
    logic               ovf;
    sa   = $signed({{32{a[31]}}, a});
    sb   = $signed({{32{b[31]}}, b});
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    ub_s = $signed(ub);
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p    = '0;
    case (f3)
      3'd0: begin p = ua * ub;   return p[31:0];  end
      3'd1: begin p = sa * sb;   return p[63:32]; end
      3'd2: begin p = sa * ub_s; return p[63:32]; end
      3'd3: begin p = ua * ub;   return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : $signed(a) / $signed(b);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : $signed(a) % $signed(b);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  // Issue one op, measure cycles from accept to out_valid, optionally stall the consumer.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    funct3   = f3;
    in1      = a;
    in2      = b;
    in_valid = 1'b1;
    sb_q.push_back({exp, 32'(exp_lat)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    funct3   = 3'd0;
    in1      = 32'hDEAD_BEEF;
    in2      = 32'h0BAD_F00D;
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb_q.pop_front();
    check_value("out_valid", out_valid, 1);
    check_value("result", result, e.res);
    check_value("latency", lat, e.lat);
    $display("txn f3=%0d in1=%h in2=%h result=%h exp=%h lat=%0d", f3, a, b, result, e.res, lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_value("hold_valid", out_valid, 1);
      check_value("hold_result", result, e.res);
      check_value("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_value("ret_out_valid", out_valid, 0);
    check_value("ret_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (3) @(posedge clk);
    #1;
    check_value("rst_in_ready", in_ready, 1);
    check_value("rst_out_valid", out_valid, 0);
    check_value("rst_result", result, 0);
    check_value("rst_busy", busy, 0);
    resetn = 1'b1;

    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0);
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT, 0);
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 5);
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT, 0);
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT, 0);
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT, 0);
    run_op(3'd5, 32'd100,        32'd7,         32'd14,        DIV_LAT, 0);
    run_op(3'd7, 32'd100,        32'd7,         32'd2,         DIV_LAT, 0);
    run_op(3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF, 1,       0);
    run_op(3'd7, 32'h1234,       32'd0,         32'h1234,      1,       0);
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,       0);
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,       0);

    for (int i = 0; i < 12; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'd0 : (i % 4 == 1) ? 32'($urandom_range(1, 50)) : $urandom;
      run_op(rf3, ra, rb, ref_res(rf3, ra, rb), ref_lat(rf3, ra, rb), 0);
    end

    // flush in IDLE alongside in_valid must not start an operation
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    funct3   = 3'd5;
    in1      = 32'd100;
    in2      = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check_value("idle_flush_busy", busy, 0);
    check_value("idle_flush_ready", in_ready, 1);

    // flush during CALC cycle 10
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_value("calc_busy", busy, 1);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_value("flush_in_ready", in_ready, 1);
    check_value("flush_out_valid", out_valid, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check_value("flush_no_valid", seen, 0);
    $display("txn flush in CALC cycle 10, out_valid rises seen=%0d", seen);

    // reset during CALC after a nonzero result is held
    run_op(3'd7, 32'd100, 32'd7, 32'd2, DIV_LAT, 0);
    @(negedge clk);
    funct3   = 3'd1;
    in1      = 32'h1234_5678;
    in2      = 32'h9ABC_DEF0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_value("midrst_in_ready", in_ready, 1);
    check_value("midrst_out_valid", out_valid, 0);
    check_value("midrst_result", result, 0);
    check_value("midrst_busy", busy, 0);
    $display("txn reset during CALC, result=%h busy=%0d", result, busy);
    resetn = 1'b1;

    run_op(3'd4, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, DIV_LAT, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
